// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state encoding, display codes and limits for the seg7_driver slice.
package seg7_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    localparam logic [3:0] MINUS_CODE = 4'hF;
    localparam logic [3:0] OVF_CODE = 4'hF;
    localparam int MAX_MAG = 999;
    localparam int NUM_DIGITS = 4;
    localparam int ITER = 16;
    function automatic logic over_range(input logic [19:0] b);
        return 10000 * int'(b[19:16]) + 1000 * int'(b[15:12]) + 100 * int'(b[11:8])
             + 10 * int'(b[7:4]) + int'(b[3:0]) > MAX_MAG;
    endfunction
endpackage

// File: rtl/seg7_driver_if.sv
// seg7_driver_if: load/value request and scanned digit outputs of seg7_driver.
interface seg7_driver_if;
    logic        load;
    logic [15:0] value;
    logic [1:0]  en;
    logic [3:0]  num2;
    logic        busy;
    logic        done;
    modport master(output load, value, input en, num2, busy, done);
    modport slave(input load, value, output en, num2, busy, done);
endinterface

// File: rtl/seg7_driver_bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, one bit per cycle, 16-bit unsigned in, 20-bit BCD out.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic [19:0] bcd_o,
    output logic        ready_o
);
    logic [19:0] bcd_q, bcd_d, adj;
    logic [15:0] mag_q, mag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        act_q, act_d;
    for (genvar n = 0; n < 5; n++) begin : g_adj
        assign adj[n*4 +: 4] = bcd_q[n*4 +: 4] >= 4'd5 ? bcd_q[n*4 +: 4] + 4'd3 : bcd_q[n*4 +: 4];
    end
    // ready marks the final shift so the controller reaches COMMIT with bcd settled
    assign ready_o = act_q && cnt_q == 5'(ITER - 1);
    assign bcd_o = bcd_q;
    always_comb begin
        act_d = act_q;
        cnt_d = cnt_q;
        bcd_d = bcd_q;
        mag_d = mag_q;
        if (start_i) begin
            act_d = 1'b1;
            cnt_d = '0;
            bcd_d = '0;
            mag_d = bin_i;
        end else if (act_q) begin
            {bcd_d, mag_d} = {adj[18:0], mag_q, 1'b0};
            cnt_d = cnt_q + 5'd1;
            act_d = !ready_o;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= 1'b0;
            cnt_q <= '0;
            bcd_q <= '0;
            mag_q <= '0;
        end else begin
            act_q <= act_d;
            cnt_q <= cnt_d;
            bcd_q <= bcd_d;
            mag_q <= mag_d;
        end
    end
endmodule

// File: rtl/seg7_driver.sv
// seg7_driver: signed 16-bit to 4-digit BCD display with continuous digit scan.
// Define SEG7_DRIVER_SAT_EN to saturate out-of-range magnitudes to 999 instead of showing FFFF.
module seg7_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input logic          clk,
    input logic          rst,
    seg7_driver_if.slave bus_io
);
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    state_t      state_q, state_d;
    logic        sign_q, done_q, start, ready, wrap;
    logic [15:0] mag, disp_q, disp_d;
    logic [19:0] bcd;
    logic [CW-1:0] ref_q;
    logic [1:0]  en_q;
    bin2bcd_seq u_conv (
        .clk    (clk),
        .rst    (rst),
        .start_i(start),
        .bin_i  (mag),
        .bcd_o  (bcd),
        .ready_o(ready)
    );
    always_comb begin
        start = state_q == IDLE && bus_io.load;
        mag = bus_io.value[15] ? -bus_io.value : bus_io.value;
        state_d = start ? SHIFT :
                  (state_q == SHIFT && ready) ? COMMIT :
                  state_q == COMMIT ? IDLE : state_q;
`ifdef SEG7_DRIVER_SAT_EN
        disp_d = {sign_q ? MINUS_CODE : 4'h0, over_range(bcd) ? 12'h999 : bcd[11:0]};
`else
        disp_d = over_range(bcd) ? {NUM_DIGITS{OVF_CODE}} : {sign_q ? MINUS_CODE : 4'h0, bcd[11:0]};
`endif
    end
    assign wrap = ref_q == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= '0;
            ref_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= start ? bus_io.value[15] : sign_q;
            done_q  <= state_q == COMMIT;
            disp_q  <= state_q == COMMIT ? disp_d : disp_q;
            ref_q   <= wrap ? '0 : ref_q + 1'b1;
            en_q    <= en_q + {1'b0, wrap};
        end
    end
    assign bus_io.en = en_q;
    assign bus_io.num2 = disp_q[{en_q, 2'b00} +: 4];
    assign bus_io.busy = state_q != IDLE;
    assign bus_io.done = done_q;
endmodule

// File: tb/tb_seg7_driver.sv
// tb_seg7_driver: table-driven conversions with a display scoreboard plus ignore/reset/handover sequences.
module tb_seg7_driver;
    typedef struct {
        logic [15:0] value;
        logic [15:0] disp;
    } vec_t;
`ifdef SEG7_DRIVER_SAT_EN
    localparam logic [15:0] POS_OVF = 16'h0999, NEG_OVF = 16'hF999;
`else
    localparam logic [15:0] POS_OVF = 16'hFFFF, NEG_OVF = 16'hFFFF;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [15:0] sb[$];
    vec_t tbl[11];
    seg7_driver_if b ();
    seg7_driver #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(b)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic read_disp(output logic [15:0] d);
        d = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d[{b.en, 2'b00} +: 4] = b.num2;
        end
    endtask

    task automatic launch(input logic [15:0] v, input logic [15:0] exp, input bit push);
        @(negedge clk);
        b.load = 1'b1;
        b.value = v;
        if (push) sb.push_back(exp);
        @(negedge clk);
        b.load = 1'b0;
        b.value = 16'($urandom);
    endtask

    // entered at the negedge right after the load edge; inj_at injects a load to be ignored
    task automatic await_done(input logic [15:0] old, input int inj_at);
        int n;
        int bn;
        logic [15:0] exp, d;
        bn = 0;
        exp = 16'hxxxx;
        for (n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (b.done) break;
            if (b.busy) bn++;
            chk("old_digits", {12'h0, b.num2}, {12'h0, old[{b.en, 2'b00} +: 4]});
            if (n == inj_at - 1) begin
                b.load = 1'b1;
                b.value = 16'd456;
            end
            if (n == inj_at) b.load = 1'b0;
        end
        chk("done_latency", 16'(n), 16'd17);
        chk("busy_cycles", 16'(bn), 16'd17);
        chk("busy_low_at_done", 16'(b.busy), 16'd0);
        chk("sb_size_at_done", 16'(sb.size()), 16'd1);
        if (sb.size() > 0) exp = sb.pop_front();
        chk("new_digit_at_done", {12'h0, b.num2}, {12'h0, exp[{b.en, 2'b00} +: 4]});
        @(negedge clk);
        chk("done_one_cycle", 16'(b.done), 16'd0);
        read_disp(d);
        chk("display", d, exp);
    endtask

    initial begin
        logic [15:0] old, d;
        int dn;
        tbl = '{'{16'd123, 16'h0123}, '{16'hFFD3, 16'hF045}, '{16'd0, 16'h0000},
                '{16'd5000, POS_OVF}, '{16'h8000, NEG_OVF}, '{16'd999, 16'h0999},
                '{16'd1000, POS_OVF}, '{16'hFC19, 16'hF999}, '{16'hFFFF, 16'hF001},
                '{16'd7, 16'h0007}, '{16'hFA24, NEG_OVF}};
        b.load = 1'b0;
        b.value = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 16'({b.en, b.num2, b.busy, b.done}), 16'd0);
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            chk("idle_en", 16'(b.en), 16'((j / 4) % 4));
            chk("idle_num2_busy_done", 16'({b.num2, b.busy, b.done}), 16'd0);
        end
        old = 16'h0000;
        foreach (tbl[i]) begin
            launch(tbl[i].value, tbl[i].disp, 1'b1);
            await_done(old, -1);
            old = tbl[i].disp;
        end
        launch(16'd123, 16'h0123, 1'b1);
        await_done(old, 5);
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b.done || b.busy) dn++;
        end
        chk("ignored_load_no_activity", 16'(dn), 16'd0);
        chk("sb_empty", 16'(sb.size()), 16'd0);
        launch(16'd789, 16'h0789, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy_done", 16'({b.busy, b.done}), 16'd0);
        chk("rst_mid_num2", 16'(b.num2), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b.done || b.busy) dn++;
        end
        chk("rst_abort_no_done", 16'(dn), 16'd0);
        read_disp(d);
        chk("rst_abort_display", d, 16'h0000);
        launch(16'd123, 16'h0123, 1'b1);
        await_done(16'h0000, -1);
        launch(16'd456, 16'h0456, 1'b1);
        await_done(16'h0123, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_driver.md
SEG7_DRIVER -- requirements
Module: seg7_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit stays selected (100 MHz -> 1 kHz per digit).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  one-cycle request to capture value; sampled only in IDLE.
REQ-005 value  input  16  signed two's-complement number to display (multiplier product).
REQ-006 en  output  2  digit select for the 7-segment decoder; 0 = rightmost digit, 3 = leftmost.
REQ-007 num2  output  4  nibble code for the currently selected digit; 4'hF is rendered by the decoder as minus sign.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when new digits are committed.

Function
REQ-010 FSM states IDLE, SHIFT, COMMIT; IDLE->SHIFT on load, SHIFT->COMMIT after 16 iterations, COMMIT->IDLE unconditionally.
REQ-011 On load in IDLE: capture sign = value[15] and magnitude = |value| as 16-bit unsigned (-32768 -> 32768), clear 20-bit BCD accumulator, clear iteration count.
REQ-012 SHIFT: per cycle, add 3 to every BCD nibble >= 5, then shift {bcd, mag} left one bit; exactly 16 cycles.
REQ-013 COMMIT: range-check BCD magnitude against 999, update display digit registers, done = 1 for that one cycle.
REQ-014 Latency: load sampled at edge k -> busy high after edges k..k+16 -> digits and done updated at edge k+17 -> busy low after edge k+17.
REQ-015 load while busy is ignored; no queueing; value changes during conversion have no effect.
REQ-016 Display digit registers hold the previous result for the whole conversion; no partial digits ever reach num2.
REQ-017 Mapping: digit0 = ones, digit1 = tens, digit2 = hundreds, digit3 = 4'hF if negative else 4'h0.
REQ-018 Zero displays 0000; -0 is impossible (sign from value[15]).
REQ-019 Refresh counter counts 0..REFRESH_DIV-1; on wrap, en increments modulo 4 (3 -> 0).
REQ-020 num2 = digit register selected by en, combinationally from registered en and digit registers, so en and num2 always change together.
REQ-021 Scan runs continuously, independent of the FSM, including during conversion.

Reset
REQ-022 rst asserted: state = IDLE, busy = 0, done = 0, en = 0, refresh counter = 0, all digit registers = 0 (display 0000), BCD/magnitude/count cleared.
REQ-023 rst mid-conversion aborts it; no done pulse, display returns to 0000.

Configuration
REQ-024 Macro SEG7_DRIVER_SAT_EN defined: magnitude > 999 saturates to 999 with sign kept (e.g. 1500 -> 0999, -1500 -> F999).
REQ-025 SEG7_DRIVER_SAT_EN undefined: magnitude > 999 shows overflow code FFFF on all four digits.

Structure
REQ-026 Shared package seg7_pkg holds: state enum (IDLE/SHIFT/COMMIT), MINUS_CODE = 4'hF, OVF_CODE = 4'hF, MAX_MAG = 999, NUM_DIGITS = 4, ITER = 16.
REQ-027 Sub-module bin2bcd_seq holds the iterative double-dabble datapath (start, 16-bit in, 20-bit BCD out, ready); seg7_driver holds FSM control, range check, digit registers and scan.

Verification
REQ-028 Reset then idle with REFRESH_DIV = 4 -> en cycles 0,1,2,3,0 every 4 clocks, num2 = 0 throughout, busy = 0, done = 0.
REQ-029 load with value = 16'd123 -> done at edge k+17; digits read 3,2,1,0 for en = 0..3; busy high for exactly 17 cycles.
REQ-030 load with value = -45 (16'hFFD3) -> digits 5,4,0,F.
REQ-031 load with value = 16'd5000 -> FFFF without macro; 0999 with SEG7_DRIVER_SAT_EN; value = 16'h8000 -> FFFF or F999 respectively.
REQ-032 load 123, second load with 456 at edge k+5 -> ignored, result 0123, single done pulse; rst at edge k+8 -> no done, display 0000, state IDLE.
REQ-033 During conversion from 0123 to 0456, sampled num2 for each en shows only old digits until edge k+17, then only new digits.
